// File: rtl/mp_pkg.sv
// Shared definitions for the 8-bit, four-register microprocessor controller:
// opcodes, FSM state encoding and instruction field positions.
package mp_pkg;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_ADDI = 2'b01;
    localparam logic [1:0] OP_SUB  = 2'b10;
    localparam logic [1:0] OP_J    = 2'b11;

    // Instruction layout: op[7:6] s[5:4] t[3:2] d[1:0]; jump target is [5:0]
    localparam int OP_MSB = 7;
    localparam int OP_LSB = 6;
    localparam int RS_MSB = 5;
    localparam int RS_LSB = 4;
    localparam int RT_MSB = 3;
    localparam int RT_LSB = 2;
    localparam int RD_MSB = 1;
    localparam int RD_LSB = 0;
    localparam int JT_MSB = 5;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4
    } state_t;

    function automatic logic [7:0] sext2(input logic [1:0] v);
        return {{6{v[1]}}, v};
    endfunction

endpackage

// File: rtl/mp_alu.sv
// Combinational 8-bit ALU: add, add-immediate (2-bit signed) and subtract,
// selected directly by the instruction opcode. Results wrap modulo 256.
module mp_alu
    import mp_pkg::*;
(
    input  logic [1:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [1:0] imm,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADD:  y = a + b;
            OP_ADDI: y = a + sext2(imm);
            OP_SUB:  y = a - b;
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/mp_control_unit.sv
// Multi-cycle fetch/decode/execute/writeback controller. Owns the FSM, pc,
// instruction register and result register; talks only to imem and the regfile.
module mp_control_unit
    import mp_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_valid,
    input  logic [7:0]      imem_data,
    output logic [1:0]      rs,
    output logic [1:0]      rt,
    input  logic [7:0]      rsData,
    input  logic [7:0]      rtData,
    output logic [1:0]      rd,
    output logic            RegWrite,
    output logic [7:0]      writeData,
    output logic [PC_W-1:0] pc,
    output logic            retire
);

    state_t          state;
    state_t          nextState;
    logic [PC_W-1:0] pcReg;
    logic [7:0]      ir;
    logic [7:0]      result;
    logic [7:0]      aluY;
    logic [1:0]      opcode;
    logic [PC_W-1:0] jumpTarget;

    assign opcode     = ir[OP_MSB:OP_LSB];
    assign jumpTarget = PC_W'(ir[JT_MSB:0]);

    mp_alu u_alu (
        .op  (opcode),
        .a   (rsData),
        .b   (rtData),
        .imm (ir[RD_MSB:RD_LSB]),
        .y   (aluY)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // A started fetch always runs to completion; run is only consulted
    // at instruction boundaries.
    always_comb begin
        nextState = state;
        case (state)
            S_IDLE:   if (run) nextState = S_FETCH;
            S_FETCH:  if (imem_valid) nextState = S_DECODE;
            S_DECODE: nextState = S_EXEC;
            S_EXEC: begin
                if (opcode == OP_J) begin
                    nextState = run ? S_FETCH : S_IDLE;
                end else begin
                    nextState = S_WB;
                end
            end
            S_WB:     nextState = run ? S_FETCH : S_IDLE;
            default:  nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcReg  <= '0;
            ir     <= 8'h00;
            result <= 8'h00;
        end else begin
            if (state == S_FETCH && imem_valid) begin
                ir    <= imem_data;
                pcReg <= pcReg + PC_W'(1);
            end
            if (state == S_EXEC) begin
                if (opcode == OP_J) begin
                    pcReg <= jumpTarget;
                end else begin
                    result <= aluY;
                end
            end
        end
    end

    // Every output is decoded from registered state so imem_valid never
    // reaches an output combinationally.
    always_comb begin
        imem_req  = (state == S_FETCH);
        imem_addr = pcReg;
        pc        = pcReg;
        rs        = ir[RS_MSB:RS_LSB];
        rt        = ir[RT_MSB:RT_LSB];
        rd        = (opcode == OP_ADDI) ? ir[RT_MSB:RT_LSB] : ir[RD_MSB:RD_LSB];
        RegWrite  = (state == S_WB);
        writeData = (state == S_WB) ? result : 8'h00;
        retire    = (state == S_WB) || (state == S_EXEC && opcode == OP_J);
    end

endmodule

// File: tb/tb_mp_control_unit.sv
// Self-checking bench for mp_control_unit with a behavioural instruction
// memory (configurable latency) and a four-entry register file model.
module tb_mp_control_unit;

    localparam int PC_W = 8;

    logic            clk;
    logic            reset;
    logic            run;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_valid;
    logic [7:0]      imem_data;
    logic [1:0]      rs;
    logic [1:0]      rt;
    logic [7:0]      rsData;
    logic [7:0]      rtData;
    logic [1:0]      rd;
    logic            RegWrite;
    logic [7:0]      writeData;
    logic [PC_W-1:0] pc;
    logic            retire;

    logic [7:0]       imem [256];
    logic [3:0][7:0]  regs;
    logic [31:0]      presetRegs;
    int               memLatency;
    int               waitCnt;
    int               checks;
    int               errors;

    typedef struct {
        logic [7:0]  instr;
        logic [31:0] regsInit;
        logic        isJump;
        logic [1:0]  expRd;
        logic [7:0]  expData;
        logic [7:0]  expPc;
    } vec_t;

    vec_t vecs [9];

    mp_control_unit #(.PC_W(PC_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_valid (imem_valid),
        .imem_data  (imem_data),
        .rs         (rs),
        .rt         (rt),
        .rsData     (rsData),
        .rtData     (rtData),
        .rd         (rd),
        .RegWrite   (RegWrite),
        .writeData  (writeData),
        .pc         (pc),
        .retire     (retire)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory answers after memLatency cycles of an uninterrupted request
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            waitCnt <= 0;
        end else if (imem_req && !imem_valid) begin
            waitCnt <= waitCnt + 1;
        end else begin
            waitCnt <= 0;
        end
    end
    assign imem_valid = imem_req && (waitCnt >= memLatency);
    assign imem_data  = imem[imem_addr];

    // Register file: presets load while reset is held, writes land at WB end
    always @(posedge clk) begin
        if (reset) begin
            regs <= presetRegs;
        end else if (RegWrite) begin
            regs[rd] <= writeData;
        end
    end
    assign rsData = regs[rs];
    assign rtData = regs[rt];

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic resetDut(input logic [31:0] preset);
        @(negedge clk);
        reset      = 1'b1;
        run        = 1'b0;
        presetRegs = preset;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // One instruction from address 0 with run dropped after the first fetch cycle
    task automatic applyStimulus(input vec_t v);
        logic [7:0] ins;
        ins = v.instr;
        imem[0] = ins;
        resetDut(v.regsInit);
        run = 1'b1;
        tick();
        checkOutput("vecFetchReq", 32'(imem_req), 32'd1);
        checkOutput("vecFetchAddr", 32'(imem_addr), 32'd0);
        run = 1'b0;
        tick();
        checkOutput("vecDecodePc", 32'(pc), 32'd1);
        checkOutput("vecDecodeReq", 32'(imem_req), 32'd0);
        checkOutput("vecRs", 32'(rs), 32'(ins[5:4]));
        checkOutput("vecRt", 32'(rt), 32'(ins[3:2]));
        tick();
        checkOutput("vecExecRetire", 32'(retire), 32'(v.isJump));
        checkOutput("vecExecRegWrite", 32'(RegWrite), 32'd0);
        tick();
        if (v.isJump) begin
            checkOutput("vecJumpPc", 32'(pc), 32'(v.expPc));
            checkOutput("vecJumpIdleReq", 32'(imem_req), 32'd0);
            checkOutput("vecJumpNoWrite", 32'(RegWrite), 32'd0);
            checkOutput("vecJumpRetireOnce", 32'(retire), 32'd0);
        end else begin
            checkOutput("vecWbRegWrite", 32'(RegWrite), 32'd1);
            checkOutput("vecWbRd", 32'(rd), 32'(v.expRd));
            checkOutput("vecWbData", 32'(writeData), 32'(v.expData));
            checkOutput("vecWbRetire", 32'(retire), 32'd1);
        end
        tick();
        checkOutput("vecIdleReq", 32'(imem_req), 32'd0);
        checkOutput("vecIdleRegWrite", 32'(RegWrite), 32'd0);
        if (!v.isJump) begin
            checkOutput("vecRegfile", 32'(regs[v.expRd]), 32'(v.expData));
        end
    endtask

    initial begin
        logic [1:0] progRd [3];
        logic [7:0] progData [3];
        int         retireCount;
        bit         found;

        checks     = 0;
        errors     = 0;
        memLatency = 0;
        run        = 1'b0;
        presetRegs = 32'h0;
        reset      = 1'b1;
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;

        //             instr  regs {r3,r2,r1,r0} jump rd    data   pc
        vecs[0] = '{8'h46, 32'h00000000, 1'b0, 2'd1, 8'hFE, 8'h00};
        vecs[1] = '{8'h98, 32'h00010000, 1'b0, 2'd0, 8'hFF, 8'h00};
        vecs[2] = '{8'h1B, 32'h00808000, 1'b0, 2'd3, 8'h00, 8'h00};
        vecs[3] = '{8'h79, 32'h7F000000, 1'b0, 2'd2, 8'h80, 8'h00};
        vecs[4] = '{8'h63, 32'h00050000, 1'b0, 2'd0, 8'h04, 8'h00};
        vecs[5] = '{8'h5C, 32'h00003300, 1'b0, 2'd3, 8'h33, 8'h00};
        vecs[6] = '{8'hB1, 32'h10000020, 1'b0, 2'd1, 8'hF0, 8'h00};
        vecs[7] = '{8'hFF, 32'h00000000, 1'b1, 2'd0, 8'h00, 8'h3F};
        vecs[8] = '{8'hD5, 32'h00000000, 1'b1, 2'd0, 8'h00, 8'h15};

        // Reset values while reset is still held
        @(negedge clk);
        checkOutput("rstReq", 32'(imem_req), 32'd0);
        checkOutput("rstPc", 32'(pc), 32'd0);
        checkOutput("rstRegWrite", 32'(RegWrite), 32'd0);
        checkOutput("rstWriteData", 32'(writeData), 32'd0);
        checkOutput("rstRsRtRd", {26'd0, rs, rt, rd}, 32'd0);
        checkOutput("rstRetire", 32'(retire), 32'd0);

        for (int i = 0; i < 9; i++) applyStimulus(vecs[i]);

        // Back-to-back program: writes land 4 cycles apart
        $display("[TB] program sequence");
        imem[0] = 8'h45;
        imem[1] = 8'h59;
        imem[2] = 8'h1B;
        progRd   = '{2'd1, 2'd2, 2'd3};
        progData = '{8'h01, 8'h02, 8'h03};
        retireCount = 0;
        resetDut(32'h0);
        run = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (retire) retireCount++;
            checkOutput("progRegWrite", 32'(RegWrite), 32'((c % 4) == 0));
            if ((c % 4) == 0) begin
                checkOutput("progRd", 32'(rd), 32'(progRd[c / 4 - 1]));
                checkOutput("progData", 32'(writeData), 32'(progData[c / 4 - 1]));
            end
            if (c == 12) run = 1'b0;
        end
        tick();
        checkOutput("progIdleReq", 32'(imem_req), 32'd0);
        checkOutput("progRetireCount", 32'(retireCount), 32'd3);
        checkOutput("progR3", 32'(regs[3]), 32'h03);

        // Jump chain: J 5 then J 0x3F at address 5
        $display("[TB] jump sequence");
        imem[0]     = 8'hC5;
        imem[5]     = 8'hFF;
        imem[8'h3F] = 8'h00;
        resetDut(32'h0);
        run = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            tick();
            checkOutput("jmpNoWrite", 32'(RegWrite), 32'd0);
            if (c == 4) checkOutput("jmpFetch5", {31'd0, imem_req} << 8 | 32'(imem_addr), 32'h105);
            if (c == 7) checkOutput("jmpFetch3F", {31'd0, imem_req} << 8 | 32'(imem_addr), 32'h13F);
        end
        run = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        checkOutput("jmpIdle", 32'(imem_req), 32'd0);

        // Slow memory with run dropped during the fetch
        $display("[TB] slow fetch sequence");
        imem[0]    = 8'h46;
        memLatency = 3;
        resetDut(32'h0);
        run = 1'b1;
        tick();
        checkOutput("slowReq1", 32'(imem_req), 32'd1);
        run = 1'b0;
        for (int c = 2; c <= 4; c++) begin
            tick();
            checkOutput("slowReqHeld", 32'(imem_req), 32'd1);
            checkOutput("slowPcHeld", 32'(pc), 32'd0);
        end
        tick();
        checkOutput("slowDecodeReq", 32'(imem_req), 32'd0);
        checkOutput("slowDecodePc", 32'(pc), 32'd1);
        tick();
        tick();
        checkOutput("slowWbRegWrite", 32'(RegWrite), 32'd1);
        checkOutput("slowWbRd", 32'(rd), 32'd1);
        checkOutput("slowWbData", 32'(writeData), 32'hFE);
        for (int c = 0; c < 3; c++) begin
            tick();
            checkOutput("slowIdleReq", 32'(imem_req), 32'd0);
        end
        memLatency = 0;

        // Asynchronous reset landing in WB
        $display("[TB] async reset sequence");
        imem[0] = 8'h46;
        imem[1] = 8'h00;
        resetDut(32'h0);
        run = 1'b1;
        for (int c = 0; c < 4; c++) tick();
        checkOutput("arstPreWb", 32'(RegWrite), 32'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arstRegWrite", 32'(RegWrite), 32'd0);
        checkOutput("arstPc", 32'(pc), 32'd0);
        checkOutput("arstWriteData", 32'(writeData), 32'd0);
        checkOutput("arstRetire", 32'(retire), 32'd0);
        checkOutput("arstRd", 32'(rd), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        checkOutput("arstRefetchReq", 32'(imem_req), 32'd1);
        checkOutput("arstRefetchAddr", 32'(imem_addr), 32'd0);
        run = 1'b0;
        for (int c = 0; c < 5; c++) tick();

        // pc wraps after fetching the last address
        $display("[TB] pc wrap sequence");
        for (int i = 0; i < 256; i++) imem[i] = 8'h00;
        resetDut(32'h0);
        run   = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 1200 && !found; c++) begin
            tick();
            if (imem_req && imem_addr == 8'hFF) found = 1'b1;
        end
        checkOutput("wrapReachedFF", 32'(found), 32'd1);
        if (found) begin
            tick();
            checkOutput("wrapPc", 32'(pc), 32'd0);
        end
        run = 1'b0;
        for (int c = 0; c < 5; c++) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mp_control_unit.md
# mp_control_unit

Multi-cycle fetch/decode/execute/writeback controller for the 8-bit, four-register microprocessor. It fetches 8-bit instructions from instruction memory through a req/valid handshake and drives the register file read addresses (`rs`, `rt`). It computes the ALU result from the returned `rsData`/`rtData` and drives `rd`/`RegWrite`/`writeData` back into the register file. It sits directly upstream and downstream of the register file, which is its only datapath partner.

## Interface
Parameters:
- `PC_W`, default 8: program counter and instruction address width; must be at least 6.

Ports:
- `clk`, in, 1: clock; all state changes on the rising edge.
- `reset`, in, 1: asynchronous, active-high; clears all state.
- `run`, in, 1: level enable; the controller fetches only while high.
- `imem_req`, out, 1: fetch request.
- `imem_addr`, out, `PC_W`: fetch address; equals `pc`.
- `imem_valid`, in, 1: fetch data valid.
- `imem_data`, in, 8: instruction word.
- `rs`, `rt`, out, 2 each: register file read addresses.
- `rsData`, `rtData`, in, 8 each: register file read data; combinational from `rs`/`rt`.
- `rd`, out, 2: register file write address.
- `RegWrite`, out, 1: register file write enable.
- `writeData`, out, 8: register file write data.
- `pc`, out, `PC_W`: current program counter.
- `retire`, out, 1: one-cycle pulse per completed instruction.

## Operation
Instruction format: `op[7:6]`, `s[5:4]`, `t[3:2]`, `d[1:0]`.
- 00 ADD: `R[d] <= R[s] + R[t]`.
- 01 ADDI: `R[t] <= R[s] + sext(d)`. The 2-bit immediate ranges from -2 to +1.
- 10 SUB: `R[d] <= R[s] - R[t]`.
- 11 J: `pc <= zext(instr[5:0])`. No register write.

Arithmetic is 8-bit two's complement. Results wrap modulo 256. There are no flags.

Address outputs:
- `rs` = IR[5:4] and `rt` = IR[3:2] at all times.
- `rd` = IR[1:0] for ADD/SUB and IR[3:2] for ADDI.

States:
- IDLE → FETCH when `run`=1.
- FETCH: `imem_req`=1.
  - When `imem_valid`=1, latch IR <= `imem_data` and set `pc <= pc+1`. The increment wraps modulo 2^PC_W.
  - Then go to DECODE.
  - `imem_req` stays high until `imem_valid`, regardless of `run`.
- DECODE: `rsData`/`rtData` settle. Go to EXEC.
- EXEC:
  - ALU ops: latch `result`, then go to WB.
  - J: load `pc` with the target, pulse `retire`, then go to FETCH if `run`=1, otherwise IDLE.
- WB: `RegWrite`=1 and `writeData`=`result` for exactly one cycle. Pulse `retire`. Then go to FETCH if `run`=1, otherwise IDLE.

Other behaviour:
- Dropping `run` mid-instruction completes that instruction. No new fetch is issued.
- `imem_valid` outside FETCH is ignored.

Reset values:
- State IDLE.
- `pc`=0, IR=0, `result`=0.
- `imem_req`=0, `RegWrite`=0, `writeData`=0.
- `rs`/`rt`/`rd`=0, `retire`=0.

## Timing
- All outputs are registered or decoded from registered state. There is no combinational path from `imem_valid` to any output.
- With zero-wait memory (valid in the first FETCH cycle):
  - ALU instructions take 4 cycles, FETCH to WB inclusive.
  - J takes 3 cycles.
- Each extra cycle of `imem_valid` latency adds one FETCH cycle.
- `RegWrite` is asserted only in WB. The register file samples at the end of the WB cycle. The next FETCH therefore sees the updated register file.
- A write to a register read by the following instruction needs no forwarding, because the stages never overlap.
- Reset asserted mid-operation:
  - Outputs return to reset values immediately, with `RegWrite` dropping asynchronously.
  - Any outstanding fetch is abandoned. The memory must tolerate a dropped `imem_req`.
- Reset released with `run`=1: FETCH of address 0 starts in the first clock after release.
- `pc` wrap: after fetching from address 2^PC_W-1, `pc`=0.

## Structure
- Package `mp_pkg` holds:
  - opcode constants `OP_ADD`, `OP_ADDI`, `OP_SUB`, `OP_J`;
  - the state encoding (IDLE, FETCH, DECODE, EXEC, WB);
  - the instruction field bit positions.
- Sub-module `mp_alu`: combinational 8-bit add/sub plus immediate sign-extension, selected by opcode.
- The FSM, `pc`, IR, and `result` registers live in the top module.

## Test plan
- Reset, then `run`=1, memory word 0 = 0x46 (ADDI R1 <- R0 + (-2)), zero-wait memory → WB in cycle 4 with `rd`=1 and `writeData`=0xFE; `retire` pulses once; `pc`=1.
- Program {ADDI R1=R0+1; ADDI R2=R1+1; ADD R3=R1+R2 (0x1B)} → writes 0x01, 0x02, 0x03 in order, 4 cycles apart.
- SUB R0 = R1 - R2 with R1=0x00 and R2=0x01 → `writeData`=0xFF (wrap).
- J 0x3F (0xFF) at address 5 → no `RegWrite`; next `imem_addr`=0x3F after 3 cycles.
- `imem_valid` delayed 3 cycles, with `run` dropped during FETCH → `imem_req` held until valid; the instruction completes; the controller then enters IDLE with `imem_req`=0.
- Async reset asserted during WB → `RegWrite`=0 within the same cycle, before the edge; `pc`=0; after release the controller refetches address 0.
